// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage (package arm_if_pkg).
package arm_if_pkg;
  localparam int          ADDR_W_DEFAULT  = 32;
  localparam int          INSTR_W         = 32;
  localparam int          PC_STEP_DEFAULT = 4;
  localparam logic [31:0] NOP_INSTR       = 32'h0;

  typedef struct packed {
    logic [INSTR_W-1:0]        instr;
    logic [ADDR_W_DEFAULT-1:0] pc4;
    logic                      valid;
  } if_id_t;
endpackage

// File: rtl/instruction_fetch_stage_pc_register.sv
// Program counter register: sync reset, branch load beats enable, word alignment.
module pc_register #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              en,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q
);
  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (ld || en) pc_d = {d[ADDR_W-1:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign q = {pc_q[ADDR_W-1:2], 2'b00};
endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC, combinational imem address, IF/ID register with freeze/flush/branch.
// Define IF_FETCH_COUNT_EN to add saturating fetch_count / stall_count outputs.
module instruction_fetch_stage
  import arm_if_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc4,
  output logic               if_id_valid
`ifdef IF_FETCH_COUNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);
  logic [ADDR_W-1:0] pc, pc_inc, pc_nxt;
  if_id_t            if_id_q, if_id_d;

  assign pc_inc = pc + ADDR_W'(PC_STEP);
  assign pc_nxt = branch_taken ? branch_addr : pc_inc;

  pc_register #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk (clk),
    .rst (rst),
    .ld  (branch_taken),
    .en  (~freeze),
    .d   (pc_nxt),
    .q   (pc)
  );

  assign imem_addr = pc;
  assign if_pc     = pc;

  // Branch inserts a bubble; pc4 of a bubble is meaningless and simply holds.
  always_comb begin
    if_id_d = if_id_q;
    if (branch_taken) begin
      if_id_d.instr = NOP_INSTR;
      if_id_d.valid = 1'b0;
    end else if (freeze) begin
      if_id_d.valid = if_id_q.valid & ~flush;
    end else begin
      if_id_d.instr = imem_rdata;
      if_id_d.pc4   = ADDR_W_DEFAULT'(pc_inc);
      if_id_d.valid = ~flush;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) if_id_q <= '0;
    else     if_id_q <= if_id_d;
  end

  assign if_id_instr = if_id_q.instr;
  assign if_id_pc4   = if_id_q.pc4[ADDR_W-1:0];
  assign if_id_valid = if_id_q.valid;

`ifdef IF_FETCH_COUNT_EN
  logic [31:0] fetch_count_q, fetch_count_d, stall_count_q, stall_count_d;
  logic        fetch_inc, stall_inc;

  // Only a fresh, unflushed capture counts; a frozen entry that stays valid does not.
  assign fetch_inc = ~branch_taken & ~freeze & ~flush;
  assign stall_inc = ~branch_taken & freeze;

  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (fetch_inc && fetch_count_q != 32'hFFFF_FFFF) fetch_count_d = fetch_count_q + 32'd1;
    if (stall_inc && stall_count_q != 32'hFFFF_FFFF) stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed vector table, wrap instance, random vs model.
module tb_instruction_fetch_stage;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, freeze, flush, branch_taken;
  logic [31:0] branch_addr, imem_addr, imem_rdata, if_pc, if_id_instr, if_id_pc4;
  logic        if_id_valid;

  logic        w_rst, w_freeze, w_flush, w_br;
  logic [31:0] w_baddr, w_imem_addr, w_imem_rdata, w_if_pc, w_instr, w_pc4;
  logic        w_valid;

`ifdef IF_FETCH_COUNT_EN
  logic [31:0] fetch_count, stall_count, w_fetch_count, w_stall_count;
`endif

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0022_0000;
      32'h4:   return 32'h0064_0000;
      32'h8:   return 32'h00A6_0000;
      32'hC:   return 32'h00E8_1000;
      default: return {~a[15:0], a[15:0]};
    endcase
  endfunction

  assign imem_rdata   = mem_word(imem_addr);
  assign w_imem_rdata = mem_word(w_imem_addr);

  instruction_fetch_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .if_pc(if_pc),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
`ifdef IF_FETCH_COUNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(w_rst), .freeze(w_freeze), .flush(w_flush),
    .branch_taken(w_br), .branch_addr(w_baddr),
    .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata), .if_pc(w_if_pc),
    .if_id_instr(w_instr), .if_id_pc4(w_pc4), .if_id_valid(w_valid)
`ifdef IF_FETCH_COUNT_EN
    , .fetch_count(w_fetch_count), .stall_count(w_stall_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst, frz, fl, br;
    logic [31:0] ba;
    logic [31:0] pc, instr, pc4;
    logic        v, chk_pc4;
    logic [31:0] fc, sc;
  } vec_t;

  function automatic vec_t mk(input logic r, f, l, b, input logic [31:0] ba,
                              input logic [31:0] pc, instr, pc4, input logic v, cp,
                              input logic [31:0] fc, sc);
    vec_t t;
    t.rst = r; t.frz = f; t.fl = l; t.br = b; t.ba = ba;
    t.pc = pc; t.instr = instr; t.pc4 = pc4; t.v = v; t.chk_pc4 = cp;
    t.fc = fc; t.sc = sc;
    return t;
  endfunction

  vec_t vq[$];

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_sc;
  logic        m_v, m_pc4_known;

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    w_rst = 1'b1; w_freeze = 1'b0; w_flush = 1'b0; w_br = 1'b0; w_baddr = '0;

    // Wrap instance: reset to 0xFFFFFFFC, one unfrozen cycle wraps to 0
    step();
    chk("wrap_reset_addr", w_imem_addr, 32'hFFFF_FFFC);
    chk("wrap_reset_valid", {31'b0, w_valid}, 32'd0);
    w_rst = 1'b0;
    step();
    chk("wrap_pc", w_if_pc, 32'h0);
    chk("wrap_pc4", w_pc4, 32'h0);
    chk("wrap_instr", w_instr, mem_word(32'hFFFF_FFFC));
    chk("wrap_valid", {31'b0, w_valid}, 32'd1);

    //            rst frz fl br  ba      pc     instr             pc4    v  cp fc sc
    vq.push_back(mk(1, 0, 0, 0, 32'h0,  32'h0,  32'h0,            32'h0,  0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,  32'h4,  mem_word(32'h0),  32'h4,  1, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,  32'h8,  mem_word(32'h4),  32'h8,  1, 1, 2, 0));
    vq.push_back(mk(0, 1, 0, 0, 32'h0,  32'h8,  mem_word(32'h4),  32'h8,  1, 1, 2, 1));
    vq.push_back(mk(0, 1, 0, 0, 32'h0,  32'h8,  mem_word(32'h4),  32'h8,  1, 1, 2, 2));
    vq.push_back(mk(0, 1, 0, 0, 32'h0,  32'h8,  mem_word(32'h4),  32'h8,  1, 1, 2, 3));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,  32'hC,  mem_word(32'h8),  32'hC,  1, 1, 3, 3));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,  32'h10, mem_word(32'hC),  32'h10, 1, 1, 4, 3));
    vq.push_back(mk(0, 1, 0, 1, 32'h18, 32'h18, 32'h0,            32'h0,  0, 0, 4, 3));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,  32'h1C, mem_word(32'h18), 32'h1C, 1, 1, 5, 3));
    vq.push_back(mk(0, 0, 0, 1, 32'h1B, 32'h18, 32'h0,            32'h0,  0, 0, 5, 3));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,  32'h1C, mem_word(32'h18), 32'h1C, 1, 1, 6, 3));
    vq.push_back(mk(1, 0, 0, 0, 32'h0,  32'h0,  32'h0,            32'h0,  0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,  32'h4,  mem_word(32'h0),  32'h4,  1, 1, 1, 0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,  32'h8,  mem_word(32'h4),  32'h8,  0, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,  32'hC,  mem_word(32'h8),  32'hC,  1, 1, 2, 0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,  32'h10, mem_word(32'hC),  32'h10, 1, 1, 3, 0));
    vq.push_back(mk(1, 0, 0, 0, 32'h0,  32'h0,  32'h0,            32'h0,  0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,  32'h4,  mem_word(32'h0),  32'h4,  1, 1, 1, 0));
    vq.push_back(mk(0, 1, 1, 0, 32'h0,  32'h4,  mem_word(32'h0),  32'h4,  0, 1, 1, 1));
    vq.push_back(mk(0, 1, 0, 0, 32'h0,  32'h4,  mem_word(32'h0),  32'h4,  0, 1, 1, 2));

    foreach (vq[i]) begin
      rst = vq[i].rst; freeze = vq[i].frz; flush = vq[i].fl;
      branch_taken = vq[i].br; branch_addr = vq[i].ba;
      step();
      chk($sformatf("vec%0d_pc", i), if_pc, vq[i].pc);
      chk($sformatf("vec%0d_imem_addr", i), imem_addr, vq[i].pc);
      chk($sformatf("vec%0d_instr", i), if_id_instr, vq[i].instr);
      if (vq[i].chk_pc4) chk($sformatf("vec%0d_pc4", i), if_id_pc4, vq[i].pc4);
      chk($sformatf("vec%0d_valid", i), {31'b0, if_id_valid}, {31'b0, vq[i].v});
`ifdef IF_FETCH_COUNT_EN
      chk($sformatf("vec%0d_fetch_count", i), fetch_count, vq[i].fc);
      chk($sformatf("vec%0d_stall_count", i), stall_count, vq[i].sc);
`endif
    end

    // Randomized run against a behavioural model; start from a clean reset
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; branch_taken = 1'b0;
    step();
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_v = 0; m_pc4_known = 1; m_fc = 0; m_sc = 0;
    for (int c = 0; c < 400; c++) begin
      rst          = ($urandom_range(0, 31) == 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      freeze       = ($urandom_range(0, 3) == 0);
      flush        = ($urandom_range(0, 4) == 0);
      branch_addr  = (c % 3 == 0) ? ($urandom_range(0, 63)) : $urandom;
      if (rst) begin
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_v = 0; m_pc4_known = 1; m_fc = 0; m_sc = 0;
      end else if (branch_taken) begin
        m_pc = branch_addr & 32'hFFFF_FFFC; m_instr = 0; m_v = 0; m_pc4_known = 0;
      end else if (freeze) begin
        m_v = m_v & ~flush;
        if (m_sc != 32'hFFFF_FFFF) m_sc++;
      end else begin
        m_instr = mem_word(m_pc);
        m_pc    = m_pc + 32'd4;
        m_pc4   = m_pc; m_pc4_known = 1;
        m_v     = ~flush;
        if (!flush && m_fc != 32'hFFFF_FFFF) m_fc++;
      end
      step();
      chk($sformatf("rnd%0d_pc", c), if_pc, m_pc);
      chk($sformatf("rnd%0d_instr", c), if_id_instr, m_instr);
      chk($sformatf("rnd%0d_valid", c), {31'b0, if_id_valid}, {31'b0, m_v});
      if (m_pc4_known) chk($sformatf("rnd%0d_pc4", c), if_id_pc4, m_pc4);
`ifdef IF_FETCH_COUNT_EN
      chk($sformatf("rnd%0d_fetch_count", c), fetch_count, m_fc);
      chk($sformatf("rnd%0d_stall_count", c), stall_count, m_sc);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
